// File: rtl/uart_cmd_parser_if.sv
// Byte-stream and command-output bundle for uart_cmd_parser.
// The parser owns the slave modport; a UART receiver plus path planner sit on the master side.
interface uart_cmd_parser_if;
    // Handshakes: rx_msg is meaningful only in a cycle with rx_complete=1, and one byte moves per strobe.
    // cmd_valid stays high with SP/EP stable until a cycle with cmd_ack=1; the command moves in that cycle.
    // cmd_error and overrun are single-cycle event pulses that need no acknowledgement.
    logic [7:0] rx_msg;
    logic       rx_complete;
    logic       cmd_ack;
    logic [4:0] SP;
    logic [4:0] EP;
    logic       cmd_valid;
    logic       cmd_error;
    logic       overrun;
    logic       busy;

    modport slave (
        input  rx_msg, rx_complete, cmd_ack,
        output SP, EP, cmd_valid, cmd_error, overrun, busy
    );

    modport master (
        output rx_msg, rx_complete, cmd_ack,
        input  SP, EP, cmd_valid, cmd_error, overrun, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// Parses "$TT-UU#" ASCII frames into start/end node indices and holds the command until acknowledged.
// A partial frame is dropped after TIMEOUT_CYCLES with no new byte.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 5_000_000,
    parameter int MAX_NODE       = 26
) (
    input  logic                   clk_50M,
    input  logic                   reset,
    uart_cmd_parser_if.slave       bus,
    output logic [2:0]             dbg_state_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [6:0]    MAX_V    = 7'(MAX_NODE);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SP_HI = 3'd1,
        SP_LO = 3'd2,
        DASH  = 3'd3,
        EP_HI = 3'd4,
        EP_LO = 3'd5,
        TERM  = 3'd6,
        HOLD  = 3'd7
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    sp_tens_q, sp_tens_d;
    logic [3:0]    ep_tens_q, ep_tens_d;
    logic [6:0]    sp_val_q, sp_val_d;
    logic [6:0]    ep_val_q, ep_val_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    sp_q, sp_d;
    logic [4:0]    ep_q, ep_d;
    logic          cmd_valid_q, cmd_valid_d;
    logic          cmd_error_q, cmd_error_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;

    logic          is_dollar;
    logic          is_digit;
    logic [3:0]    digit;

    function automatic logic [6:0] node_value(input logic [3:0] tens, input logic [3:0] units);
        return ({3'b000, tens} * 7'd10) + {3'b000, units};
    endfunction

    always_ff @(posedge clk_50M) begin
        if (reset) begin
            state_q     <= IDLE;
            sp_tens_q   <= '0;
            ep_tens_q   <= '0;
            sp_val_q    <= '0;
            ep_val_q    <= '0;
            cnt_q       <= '0;
            sp_q        <= '0;
            ep_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_error_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sp_tens_q   <= sp_tens_d;
            ep_tens_q   <= ep_tens_d;
            sp_val_q    <= sp_val_d;
            ep_val_q    <= ep_val_d;
            cnt_q       <= cnt_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_error_q <= cmd_error_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sp_tens_d   = sp_tens_q;
        ep_tens_d   = ep_tens_q;
        sp_val_d    = sp_val_q;
        ep_val_d    = ep_val_q;
        cnt_d       = cnt_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        cmd_error_d = 1'b0;
        overrun_d   = 1'b0;

        is_dollar = (bus.rx_msg == 8'h24);
        is_digit  = (bus.rx_msg >= 8'h30) && (bus.rx_msg <= 8'h39);
        digit     = bus.rx_msg[3:0];

        // Inter-byte timer: any byte restarts it; it only runs while a frame is partially received.
        if (bus.rx_complete) begin
            cnt_d = '0;
        end else if (state_q != IDLE && state_q != HOLD) begin
            cnt_d = (cnt_q == TMO_LAST) ? cnt_q : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.rx_complete && is_dollar) begin
                    state_d = SP_HI;
                end
            end
            HOLD: begin
                if (bus.cmd_ack) begin
                    state_d = IDLE;
                end else if (bus.rx_complete) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                if (bus.rx_complete) begin
                    if (is_dollar) begin
                        cmd_error_d = 1'b1;
                        state_d     = SP_HI;
                    end else begin
                        cmd_error_d = 1'b1;
                        state_d     = IDLE;
                        case (state_q)
                            SP_HI: if (is_digit) begin
                                cmd_error_d = 1'b0;
                                sp_tens_d   = digit;
                                state_d     = SP_LO;
                            end
                            SP_LO: if (is_digit) begin
                                cmd_error_d = 1'b0;
                                sp_val_d    = node_value(sp_tens_q, digit);
                                state_d     = DASH;
                            end
                            DASH: if (bus.rx_msg == 8'h2D) begin
                                cmd_error_d = 1'b0;
                                state_d     = EP_HI;
                            end
                            EP_HI: if (is_digit) begin
                                cmd_error_d = 1'b0;
                                ep_tens_d   = digit;
                                state_d     = EP_LO;
                            end
                            EP_LO: if (is_digit) begin
                                cmd_error_d = 1'b0;
                                ep_val_d    = node_value(ep_tens_q, digit);
                                state_d     = TERM;
                            end
                            TERM: if (bus.rx_msg == 8'h23 && sp_val_q <= MAX_V && ep_val_q <= MAX_V) begin
                                cmd_error_d = 1'b0;
                                sp_d        = sp_val_q[4:0];
                                ep_d        = ep_val_q[4:0];
                                state_d     = HOLD;
                            end
                            default: ;
                        endcase
                    end
                end else if (cnt_q == TMO_LAST) begin
                    cmd_error_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase

        if (state_d == IDLE) begin
            cnt_d = '0;
        end
        cmd_valid_d = (state_d == HOLD);
        busy_d      = (state_d != IDLE);
    end

    assign bus.SP        = sp_q;
    assign bus.EP        = ep_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_error = cmd_error_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = busy_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized bench for uart_cmd_parser: a frame-level reference model feeds an event scoreboard
// that a negedge monitor drains whenever the DUT pulses or raises cmd_valid.
module tb_uart_cmd_parser;
  localparam int TMO  = 100;
  localparam int MAXN = 26;
  localparam int EW   = 44;
  localparam logic [1:0] K_ERR = 2'd1;
  localparam logic [1:0] K_OVR = 2'd2;
  localparam logic [1:0] K_CMD = 2'd3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] dbg_state;
  int         edge_cnt = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  bit         mon_en = 1'b0;
  logic       prev_valid = 1'b0;

  // scoreboard: {kind[43:42], sp[41:37], ep[36:32], edge[31:0]}
  logic [EW-1:0] exp_q[$];

  // reference model state
  logic [7:0] frame_q[$];
  bit         m_hold = 1'b0;
  int         m_idle = 0;
  logic [4:0] exp_sp = '0;
  logic [4:0] exp_ep = '0;
  logic       exp_valid = 1'b0;
  logic       exp_busy = 1'b0;
  string      pat = "$DD-DD#";

  uart_cmd_parser_if bus();

  uart_cmd_parser #(.TIMEOUT_CYCLES(TMO), .MAX_NODE(MAXN)) dut (
    .clk_50M     (clk),
    .reset       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // reference model, evaluated once per clock edge with the inputs that edge sampled
  function automatic bit fits(input int pos, input logic [7:0] b);
    if (pat[pos] == "D") return (b >= 8'h30 && b <= 8'h39);
    return (b == 8'(pat[pos]));
  endfunction

  task automatic push_ev(input logic [1:0] k, input logic [4:0] s, input logic [4:0] e);
    exp_q.push_back({k, s, e, 32'(edge_cnt)});
  endtask

  task automatic model(input logic v, input logic [7:0] b, input logic a, input logic r);
    int sp, ep;
    if (r) begin
      frame_q.delete();
      m_hold = 0;
      m_idle = 0;
      exp_sp = '0;
      exp_ep = '0;
    end else if (m_hold) begin
      if (a) m_hold = 0;
      else if (v) push_ev(K_OVR, 0, 0);
    end else if (v) begin
      m_idle = 0;
      if (b == 8'h24) begin
        if (frame_q.size() > 0) push_ev(K_ERR, 0, 0);
        frame_q.delete();
        frame_q.push_back(b);
      end else if (frame_q.size() == 0) begin
      end else if (!fits(frame_q.size(), b)) begin
        push_ev(K_ERR, 0, 0);
        frame_q.delete();
      end else begin
        frame_q.push_back(b);
        if (frame_q.size() == 7) begin
          sp = (int'(frame_q[1]) - 48) * 10 + (int'(frame_q[2]) - 48);
          ep = (int'(frame_q[4]) - 48) * 10 + (int'(frame_q[5]) - 48);
          if (sp <= MAXN && ep <= MAXN) begin
            exp_sp = 5'(sp);
            exp_ep = 5'(ep);
            m_hold = 1;
            push_ev(K_CMD, exp_sp, exp_ep);
          end else begin
            push_ev(K_ERR, 0, 0);
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        push_ev(K_ERR, 0, 0);
        frame_q.delete();
        m_idle = 0;
      end
    end
    exp_valid = m_hold;
    exp_busy  = m_hold || (frame_q.size() > 0);
  endtask

  // driver tasks
  task automatic step(input logic v, input logic [7:0] b, input logic a, input logic r);
    rst             = r;
    bus.rx_complete = v;
    bus.rx_msg      = v ? b : 8'($urandom_range(0, 255));
    bus.cmd_ack     = a;
    @(posedge clk);
    #1;
    model(v, b, a, r);
    rst             = 1'b0;
    bus.rx_complete = 1'b0;
    bus.cmd_ack     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic ack();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, 8'(s[i]), 1'b0, 1'b0);
  endtask

  // monitor / scoreboard
  task automatic chk_event(input logic [1:0] k, input logic [4:0] s, input logic [4:0] e);
    logic [EW-1:0] it;
    n_checks++;
    if (exp_q.size() == 0 || exp_q[0][31:0] != 32'(edge_cnt)) begin
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at edge %0d expected no event", k, edge_cnt);
    end else begin
      it = exp_q.pop_front();
      if (it[43:42] != k || (k == K_CMD && (it[41:37] != s || it[36:32] != e))) begin
        n_fail++;
        $display("FAIL event_kind: got kind %0d sp %0d ep %0d expected kind %0d sp %0d ep %0d",
                 k, s, e, it[43:42], it[41:37], it[36:32]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0][31:0] < 32'(edge_cnt)) begin
        n_checks++;
        n_fail++;
        $display("FAIL missing_event: got nothing expected kind %0d at edge %0d", exp_q[0][43:42], exp_q[0][31:0]);
        void'(exp_q.pop_front());
      end
      if (bus.cmd_error) chk_event(K_ERR, bus.SP, bus.EP);
      if (bus.overrun) chk_event(K_OVR, bus.SP, bus.EP);
      if (bus.cmd_valid && !prev_valid) chk_event(K_CMD, bus.SP, bus.EP);
      n_checks++;
      if ({bus.cmd_valid, bus.busy, bus.SP, bus.EP} !== {exp_valid, exp_busy, exp_sp, exp_ep}) begin
        n_fail++;
        $display("FAIL levels @%0d: got valid %b busy %b sp %0d ep %0d expected valid %b busy %b sp %0d ep %0d",
                 edge_cnt, bus.cmd_valid, bus.busy, bus.SP, bus.EP, exp_valid, exp_busy, exp_sp, exp_ep);
      end
    end
    prev_valid = bus.cmd_valid;
  end

  // stimulus
  initial begin
    logic [7:0] fr[7];
    bus.rx_msg      = 8'h00;
    bus.rx_complete = 1'b0;
    bus.cmd_ack     = 1'b0;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    mon_en = 1'b1;
    idle(2);

    send_str("$03-17#");
    idle(3);
    ack();
    idle(2);

    send_str("$05-27#");
    idle(3);

    send_str("$0$12-04#");
    idle(2);
    ack();

    send_str("$1");
    idle(TMO + 5);
    send_str("$01-02#");
    idle(1000);
    ack();
    idle(2);

    send_str("$03-04#");
    idle(1);
    step(1'b1, 8'h58, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h58, 1'b1, 1'b0);
    idle(2);

    send_str("$02-");
    step(1'b1, 8'h31, 1'b1, 1'b1);
    idle(2);
    send_str("$00-00#");
    idle(1);
    ack();
    send_str("$26-26#");
    ack();
    send_str("$27-00#");
    idle(2);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 5) == 0) step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 1'b0);
      fr[0] = 8'h24;
      fr[1] = 8'h30 + 8'($urandom_range(0, 3));
      fr[2] = 8'h30 + 8'($urandom_range(0, 9));
      fr[3] = 8'h2D;
      fr[4] = 8'h30 + 8'($urandom_range(0, 3));
      fr[5] = 8'h30 + 8'($urandom_range(0, 9));
      fr[6] = 8'h23;
      if ($urandom_range(0, 4) == 0) fr[$urandom_range(0, 6)] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 7; i++) begin
        step(1'b1, fr[i], 1'($urandom_range(0, 7) == 0), 1'b0);
        for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
        if ($urandom_range(0, 150) == 0) idle(TMO + $urandom_range(0, 3) - 1);
      end
      if ($urandom_range(0, 3) == 0) step(1'b0, 8'h00, 1'b1, 1'b0);
      if ($urandom_range(0, 40) == 0) step(1'b0, 8'h00, 1'b0, 1'b1);
    end

    idle(2);
    ack();
    idle(TMO + 5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
